reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with req0 winning.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has a write pending.
REQ-005 SHALL have port req0_reg  input  5  destination register of requester 0.
REQ-006 SHALL have port req0_data  input  32  write data of requester 0.
REQ-007 SHALL have port req0_ready  output  1  requester 0 granted this cycle.
REQ-008 SHALL have ports req1_valid, req1_reg, req1_data and req1_ready, identical to the req0 ports, for requester 1.
REQ-009 SHALL have port claim_valid  input  1  issue logic reserves a destination register.
REQ-010 SHALL have port claim_reg  input  5  register being reserved.
REQ-011 SHALL have port RegWrite  output  1  write enable to the register file.
REQ-012 SHALL have port Write_register  output  5  register-file write address.
REQ-013 SHALL have port Write_data  output  32  register-file write data.
REQ-014 SHALL have port busy  output  32  per-register pending-write scoreboard.

Function
REQ-015 SHALL define a handshake as reqN_valid && reqN_ready sampled at a rising edge; at most one reqN_ready SHALL be high in any cycle.
REQ-016 SHALL derive reqN_ready combinationally from the valids and the priority pointer, with no combinational dependence on reqN_reg or reqN_data.
REQ-017 SHALL grant the only valid requester when exactly one reqN_valid is high.
REQ-018 SHALL, when both requesters are valid and RR_EN=1, grant the requester not granted at the most recent handshake, with req0 preferred after reset.
REQ-019 SHALL, when both requesters are valid and RR_EN=0, always grant req0.
REQ-020 SHALL update the priority pointer only on a handshake.
REQ-021 SHALL drive RegWrite=1, Write_register=reqN_reg and Write_data=reqN_data for exactly the one cycle after the handshake cycle (latency 1); otherwise RegWrite=0 and Write_register/Write_data hold their last values.
REQ-022 SHALL, at a handshake with reqN_reg=0, consume the request while keeping RegWrite=0 in the following cycle.
REQ-023 SHALL sustain back-to-back handshakes, one per cycle, giving up to 32-bit x 1 write per cycle throughput.
REQ-024 SHALL require requesters to hold valid, reg and data stable until their handshake; the block does not check this.
REQ-025 SHALL set busy[claim_reg] at a rising edge with claim_valid=1.
REQ-026 SHALL clear busy[r] at the rising edge of a handshake targeting register r.
REQ-027 SHALL let the set win when a claim and a clear hit the same register in the same cycle.
REQ-028 SHALL leave busy[r] at 1 when register r is claimed while already busy; the scoreboard keeps no count.
REQ-029 SHALL hold busy[0] at 0 permanently.
REQ-030 SHALL allow writes without a prior claim; clearing an already-clear bit has no effect.

Reset
REQ-031 SHALL, while reset=1 at an edge, clear RegWrite, Write_register, Write_data and busy to 0 and return the priority pointer to req0.
REQ-032 SHALL hold req0_ready=req1_ready=0 during any cycle in which reset=1.
REQ-033 SHALL discard a write pending from the cycle before reset, so that RegWrite=0 in the cycle after the reset edge.
REQ-034 SHALL ignore claims presented in a reset cycle.

Verification
REQ-035 SHALL cover single requester: req0 valid, reg=5, data=0xDEADBEEF, cycle N -> req0_ready=1 in N; RegWrite=1, Write_register=5, Write_data=0xDEADBEEF in N+1; RegWrite=0 in N+2.
REQ-036 SHALL cover contention with RR_EN=1: both valid for 4 cycles after reset -> grants req0, req1, req0, req1, with the writes appearing one cycle later each.
REQ-037 SHALL cover contention with RR_EN=0: both valid for 3 cycles -> req0 granted every cycle and req1_ready stays 0.
REQ-038 SHALL cover the scoreboard: claim reg 7 -> busy=0x80; a later handshake on reg 7 clears it; a claim and a handshake on reg 7 in the same cycle leave busy[7]=1.
REQ-039 SHALL cover register 0: claim reg 0 plus a handshake to reg 0 -> busy stays 0, RegWrite stays 0, and the request is consumed.
REQ-040 SHALL cover reset mid-operation: handshake in cycle N and reset=1 in N+1 -> RegWrite=0 and busy=0 after that edge, and both readies are 0 during N+1.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with a one-cycle write pipeline
// and a per-register pending-write scoreboard (claims set, writes clear).
module reg_write_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        claim_valid,
  input  logic [4:0]  claim_reg,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data,
  output logic [31:0] busy
);

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } prio_t;

  prio_t       prio_reg, prio_next;
  logic        grant0, grant1, hs;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  logic        regwrite_reg;
  logic [4:0]  wr_addr_reg;
  logic [31:0] wr_data_reg;
  logic [31:0] busy_reg, busy_next;

  always_ff @(posedge clk) begin
    if (reset) prio_reg <= PRI_REQ0;
    else       prio_reg <= prio_next;
  end

  // Grants depend only on valids, reset and the pointer, never on reg/data.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    prio_next = prio_reg;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN != 0 && prio_reg == PRI_REQ1) grant1 = 1'b1;
        else                                    grant0 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    if (grant0)      prio_next = PRI_REQ1;
    else if (grant1) prio_next = PRI_REQ0;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign hs         = grant0 | grant1;
  assign win_addr   = grant1 ? req1_reg  : req0_reg;
  assign win_data   = grant1 ? req1_data : req0_data;

  // Writes to r0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      regwrite_reg <= hs && (win_addr != 5'd0);
      if (hs && (win_addr != 5'd0)) begin
        wr_addr_reg <= win_addr;
        wr_data_reg <= win_data;
      end
    end
  end

  // A claim on the same register as a completing write leaves the bit set.
  assign busy_next[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (claim_valid && claim_reg == 5'(gi)) ||
                             (busy_reg[gi] && !(hs && win_addr == 5'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign RegWrite       = regwrite_reg;
  assign Write_register = wr_addr_reg;
  assign Write_data     = wr_data_reg;
  assign busy           = busy_reg;

endmodule
